// File: rtl/hazard3_ahb_sram_pkg.sv
// hazard3_ahb_sram_pkg: shared AHB encodings, data-phase states and byte-mask helper
package hazard3_ahb_sram_pkg;
   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ  = 2'b11;
   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   typedef enum logic [2:0] {DPH_NONE, DPH_READ, DPH_WRITE, DPH_ERR1, DPH_ERR2} dphase_t;
   function automatic logic [3:0] byte_mask(input logic [1:0] addr, input logic [2:0] size);
      return size == HSIZE_BYTE ? 4'b0001 << addr : size == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hf;
   endfunction
endpackage

// File: rtl/hazard3_ahb_sram_if.sv
// hazard3_ahb_sram_if: AHB-Lite subordinate port bundle
interface hazard3_ahb_sram_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic              hready;
   logic              hready_resp;
   logic              hresp;
   logic              hsel;
   logic [W_ADDR-1:0] haddr;
   logic              hwrite;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic [W_DATA-1:0] hwdata;
   logic [W_DATA-1:0] hrdata;
   modport master (output hready, hsel, haddr, hwrite, htrans, hsize, hwdata, input hready_resp, hresp, hrdata);
   modport slave (input hready, hsel, haddr, hwrite, htrans, hsize, hwdata, output hready_resp, hresp, hrdata);
endinterface

// File: rtl/hazard3_ahb_sram_wbuf.sv
// hazard3_ahb_sram_wbuf: one-entry write buffer with per-lane read forwarding
module hazard3_ahb_sram_wbuf #(
   parameter int W_ADDR = 11,
   parameter int W_DATA = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [W_ADDR-1:0]   load_addr,
   input  logic [W_DATA/8-1:0] load_mask,
   input  logic [W_DATA-1:0]   load_data,
   input  logic                drain,
   input  logic [W_ADDR-1:0]   fwd_addr,
   input  logic [W_DATA-1:0]   fwd_rdata_in,
   output logic [W_DATA-1:0]   fwd_rdata_out,
   output logic                vld,
   output logic [W_ADDR-1:0]   addr,
   output logic [W_DATA/8-1:0] mask,
   output logic [W_DATA-1:0]   data
);
   logic                vld_q, vld_d;
   logic [W_ADDR-1:0]   addr_q, addr_d;
   logic [W_DATA/8-1:0] mask_q, mask_d;
   logic [W_DATA-1:0]   data_q, data_d;
   logic                hit;

   // A load in the same cycle as a drain wins: the old entry goes to SRAM, the new one stays
   always_comb begin
      vld_d  = load || (vld_q && !drain);
      addr_d = load ? load_addr : addr_q;
      mask_d = load ? load_mask : mask_q;
      data_d = load ? load_data : data_q;
   end

   // Entry storage; reset drops any pending write
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         addr_q <= '0;
         mask_q <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         addr_q <= addr_d;
         mask_q <= mask_d;
         data_q <= data_d;
      end
   end

   // Lanes held in the buffer for the same word override stale SRAM data
   always_comb begin
      hit = vld_q && addr_q == fwd_addr;
      fwd_rdata_out = fwd_rdata_in;
      for (int i = 0; i < W_DATA / 8; i++)
         if (hit && mask_q[i]) fwd_rdata_out[8*i +: 8] = data_q[8*i +: 8];
   end

   assign vld  = vld_q;
   assign addr = addr_q;
   assign mask = mask_q;
   assign data = data_q;
endmodule

// File: rtl/hazard3_ahb_sram.sv
// hazard3_ahb_sram: zero-wait AHB-Lite subordinate in front of a single-port synchronous SRAM
module hazard3_ahb_sram
   import hazard3_ahb_sram_pkg::*;
#(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32,
   parameter int DEPTH = 2048,
   localparam int W_SRAM_ADDR = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   hazard3_ahb_sram_if.slave      ahbls,
   output logic [W_SRAM_ADDR-1:0] sram_addr,
   output logic                   sram_ce,
   output logic                   sram_we,
   output logic [W_DATA/8-1:0]    sram_wbyte_en,
   output logic [W_DATA-1:0]      sram_wdata,
   input  logic [W_DATA-1:0]      sram_rdata
);
   localparam logic [W_ADDR-3:0] DEPTH_W = (W_ADDR - 2)'(DEPTH);

   logic                   aph, legal, rd_aph, wbuf_drain, wbuf_vld;
   logic [W_SRAM_ADDR-1:0] aph_idx, wbuf_addr;
   logic [W_DATA/8-1:0]    wbuf_mask;
   logic [W_DATA-1:0]      wbuf_data, fwd_rdata;
   dphase_t                state_q, state_d;
   logic                   hready_resp_q, hready_resp_d, hresp_q, hresp_d;
   logic [W_SRAM_ADDR-1:0] dph_addr_q, dph_addr_d;
   logic [W_DATA/8-1:0]    dph_mask_q, dph_mask_d;

   // Address-phase decode: acceptance, legality and next data-phase state
   always_comb begin
      aph = ahbls.hsel && (ahbls.htrans == HTRANS_NSEQ || ahbls.htrans == HTRANS_SEQ) && ahbls.hready;
      legal = ahbls.hsize <= HSIZE_WORD && ahbls.haddr[W_ADDR-1:2] < DEPTH_W &&
              (ahbls.hsize == HSIZE_BYTE || (ahbls.hsize == HSIZE_HALF && !ahbls.haddr[0]) || ahbls.haddr[1:0] == 2'b00);
      aph_idx = ahbls.haddr[W_SRAM_ADDR+1:2];
      rd_aph = aph && legal && !ahbls.hwrite;
      state_d = state_q == DPH_ERR1 ? DPH_ERR2 : !aph ? DPH_NONE : !legal ? DPH_ERR1 : ahbls.hwrite ? DPH_WRITE : DPH_READ;
      hready_resp_d = state_d != DPH_ERR1;
      hresp_d = state_d == DPH_ERR1 || state_d == DPH_ERR2;
      dph_addr_d = aph && legal ? aph_idx : dph_addr_q;
      dph_mask_d = aph && legal ? byte_mask(ahbls.haddr[1:0], ahbls.hsize) : dph_mask_q;
   end

   // Data-phase FSM with registered bus response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= DPH_NONE;
         hready_resp_q <= 1'b1;
         hresp_q       <= 1'b0;
         dph_addr_q    <= '0;
         dph_mask_q    <= '0;
      end else begin
         state_q       <= state_d;
         hready_resp_q <= hready_resp_d;
         hresp_q       <= hresp_d;
         dph_addr_q    <= dph_addr_d;
         dph_mask_q    <= dph_mask_d;
      end
   end

   hazard3_ahb_sram_wbuf #(.W_ADDR(W_SRAM_ADDR), .W_DATA(W_DATA)) u_wbuf (
      .clk           (clk),
      .rst           (rst),
      .load          (state_q == DPH_WRITE),
      .load_addr     (dph_addr_q),
      .load_mask     (dph_mask_q),
      .load_data     (ahbls.hwdata),
      .drain         (wbuf_drain),
      .fwd_addr      (dph_addr_q),
      .fwd_rdata_in  (sram_rdata),
      .fwd_rdata_out (fwd_rdata),
      .vld           (wbuf_vld),
      .addr          (wbuf_addr),
      .mask          (wbuf_mask),
      .data          (wbuf_data)
   );

   // SRAM port: reads take priority, otherwise the buffered write drains
   always_comb begin
      wbuf_drain    = wbuf_vld && !rd_aph;
      sram_ce       = rd_aph || wbuf_vld;
      sram_we       = wbuf_drain;
      sram_addr     = rd_aph ? aph_idx : wbuf_drain ? wbuf_addr : '0;
      sram_wbyte_en = wbuf_drain ? wbuf_mask : '0;
      sram_wdata    = wbuf_drain ? wbuf_data : '0;
   end

   assign ahbls.hready_resp = hready_resp_q;
   assign ahbls.hresp       = hresp_q;
   assign ahbls.hrdata      = state_q == DPH_READ ? fwd_rdata : '0;
endmodule

// File: tb/tb_hazard3_ahb_sram.sv
// tb_hazard3_ahb_sram: scoreboard bench for the AHB-Lite SRAM subordinate
module tb_hazard3_ahb_sram;
   localparam int DEPTH = 2048;
   localparam int K_NONE = 0, K_READ = 1, K_WRITE = 2, K_ERR1 = 3, K_ERR2 = 4;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] sram_addr;
   logic        sram_ce, sram_we;
   logic [3:0]  sram_wbyte_en;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = '0;
   logic [31:0] sram_mem [DEPTH] = '{default: '0};
   logic [31:0] ref_mem [DEPTH];
   exp_t        q[$];
   int          last_kind = K_NONE;
   logic        pend_wr = 1'b0;
   logic [31:0] pend_wdata = '0;
   logic        s_ce, s_we;
   logic [3:0]  s_be;
   int          vectors = 0;
   int          errors = 0;

   hazard3_ahb_sram_if #(.W_ADDR(32), .W_DATA(32)) bus ();
   assign bus.hready = bus.hready_resp;

   hazard3_ahb_sram #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .ahbls         (bus),
      .sram_addr     (sram_addr),
      .sram_ce       (sram_ce),
      .sram_we       (sram_we),
      .sram_wbyte_en (sram_wbyte_en),
      .sram_wdata    (sram_wdata),
      .sram_rdata    (sram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) begin
            for (int i = 0; i < 4; i++)
               if (sram_wbyte_en[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   task automatic step(input logic act, input logic wr, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
      exp_t e, n;
      logic legal;
      logic rdy, resp;
      logic [31:0] dat;
      bus.hsel   = act;
      bus.htrans = act ? 2'b10 : 2'b00;
      bus.hwrite = wr;
      bus.haddr  = addr;
      bus.hsize  = size;
      bus.hwdata = pend_wr ? pend_wdata : 32'h0;
      @(negedge clk);
      s_ce = sram_ce;
      s_we = sram_we;
      s_be = sram_wbyte_en;
      if (q.size() != 0) begin
         e = q.pop_front();
         rdy  = e.kind != K_ERR1;
         resp = e.kind == K_ERR1 || e.kind == K_ERR2;
         dat  = e.kind == K_READ ? e.data : 32'h0;
         vectors++;
         if (bus.hready_resp !== rdy || bus.hresp !== resp || bus.hrdata !== dat) begin
            errors++;
            $display("FAIL dphase kind=%0d: got ready=%b resp=%b rdata=%h, want ready=%b resp=%b rdata=%h",
                     e.kind, bus.hready_resp, bus.hresp, bus.hrdata, rdy, resp, dat);
         end
      end
      legal = size <= 3'd2 && (addr & ((32'd1 << size) - 32'd1)) == 32'd0 && addr < DEPTH * 4;
      n.data = 32'h0;
      if (last_kind == K_ERR1) n.kind = K_ERR2;
      else if (!act) n.kind = K_NONE;
      else if (!legal) n.kind = K_ERR1;
      else if (wr) begin
         n.kind = K_WRITE;
         for (int i = 0; i < 4; i++)
            if (i >= int'(addr[1:0]) && i < int'(addr[1:0]) + (1 << size))
               ref_mem[addr[12:2]][8*i +: 8] = wd[8*i +: 8];
      end else begin
         n.kind = K_READ;
         n.data = ref_mem[addr[12:2]];
      end
      pend_wr = n.kind == K_WRITE;
      pend_wdata = wd;
      last_kind = n.kind;
      q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      step(1'b1, 1'b1, addr, 3'd2, data);
      idle(2);
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.hready_resp !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus: got ready=%b resp=%b rdata=%h, want 1 0 0", bus.hready_resp, bus.hresp, bus.hrdata);
      end
      vectors++;
      if (sram_ce !== 1'b0 || sram_we !== 1'b0 || sram_wbyte_en !== 4'h0 || sram_addr !== 11'h0 || sram_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_sram: got ce=%b we=%b be=%h addr=%h wdata=%h, want all zero",
                  sram_ce, sram_we, sram_wbyte_en, sram_addr, sram_wdata);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_raw;
      step(1'b1, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
      step(1'b1, 1'b0, 32'h10, 3'd2, 32'h0);
      vectors++;
      if (s_we !== 1'b0) begin errors++; $display("FAIL raw_no_we1: got we=%b, want 0", s_we); end
      step(1'b1, 1'b0, 32'h10, 3'd2, 32'h0);
      vectors++;
      if (s_we !== 1'b0) begin errors++; $display("FAIL raw_no_we2: got we=%b, want 0", s_we); end
      idle(1);
      vectors++;
      if (s_we !== 1'b1 || s_be !== 4'hf) begin errors++; $display("FAIL raw_drain: got we=%b be=%h, want 1 f", s_we, s_be); end
      idle(1);
   endtask

   task automatic test_byte_merge;
      preload(32'h20, 32'h11223344);
      step(1'b1, 1'b1, 32'h23, 3'd0, 32'hAA000000);
      step(1'b1, 1'b0, 32'h20, 3'd2, 32'h0);
      idle(1);
      vectors++;
      if (s_we !== 1'b1 || s_be !== 4'b1000) begin errors++; $display("FAIL byte_drain: got we=%b be=%b, want 1 1000", s_we, s_be); end
      step(1'b1, 1'b0, 32'h20, 3'd2, 32'h0);
      idle(1);
      vectors++;
      if (sram_mem[8] !== 32'hAA223344) begin errors++; $display("FAIL byte_sram: got %h, want aa223344", sram_mem[8]); end
   endtask

   task automatic test_oob;
      step(1'b1, 1'b0, DEPTH * 4, 3'd2, 32'h0);
      vectors++;
      if (s_ce !== 1'b0) begin errors++; $display("FAIL oob_ce_aph: got ce=%b, want 0", s_ce); end
      idle(1);
      vectors++;
      if (s_ce !== 1'b0) begin errors++; $display("FAIL oob_ce_err1: got ce=%b, want 0", s_ce); end
      idle(1);
      vectors++;
      if (s_ce !== 1'b0) begin errors++; $display("FAIL oob_ce_err2: got ce=%b, want 0", s_ce); end
      idle(1);
   endtask

   task automatic test_misalign;
      preload(32'h0, 32'h55AA55AA);
      step(1'b1, 1'b1, 32'h1, 3'd1, 32'h12345678);
      idle(2);
      step(1'b1, 1'b1, 32'h0, 3'd3, 32'h87654321);
      idle(2);
      step(1'b1, 1'b0, 32'h0, 3'd2, 32'h0);
      idle(1);
      vectors++;
      if (sram_mem[0] !== 32'h55AA55AA) begin errors++; $display("FAIL misalign_sram: got %h, want 55aa55aa", sram_mem[0]); end
   endtask

   task automatic test_hold;
      step(1'b1, 1'b1, 32'h40, 3'd2, 32'h12345678);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 32'h100 + 32'(4 * i), 3'd2, 32'h0);
         vectors++;
         if (s_we !== 1'b0) begin errors++; $display("FAIL hold_no_we[%0d]: got we=%b, want 0", i, s_we); end
      end
      step(1'b1, 1'b0, 32'h40, 3'd2, 32'h0);
      idle(1);
      vectors++;
      if (s_we !== 1'b1) begin errors++; $display("FAIL hold_drain: got we=%b, want 1", s_we); end
      idle(1);
      vectors++;
      if (s_we !== 1'b0) begin errors++; $display("FAIL hold_single_drain: got we=%b, want 0", s_we); end
   endtask

   task automatic test_rst_mid;
      preload(32'h60, 32'hCAFEF00D);
      step(1'b1, 1'b1, 32'h60, 3'd2, 32'h0BADBEEF);
      ref_mem[24] = 32'hCAFEF00D;
      bus.hsel = 1'b0;
      bus.htrans = 2'b00;
      bus.hwdata = 32'h0BADBEEF;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.hwdata = 32'h0;
      q.delete();
      last_kind = K_NONE;
      pend_wr = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.hready_resp !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_bus: got ready=%b resp=%b rdata=%h, want 1 0 0", bus.hready_resp, bus.hresp, bus.hrdata);
      end
      vectors++;
      if (sram_ce !== 1'b0 || sram_we !== 1'b0 || sram_wbyte_en !== 4'h0 || sram_addr !== 11'h0 || sram_wdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_sram: got ce=%b we=%b be=%h addr=%h wdata=%h, want all zero",
                  sram_ce, sram_we, sram_wbyte_en, sram_addr, sram_wdata);
      end
      @(posedge clk);
      #1;
      idle(1);
      vectors++;
      if (s_we !== 1'b0) begin errors++; $display("FAIL rst_mid_no_drain: got we=%b, want 0", s_we); end
      step(1'b1, 1'b0, 32'h60, 3'd2, 32'h0);
      idle(2);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      bus.hsel = 1'b0;
      bus.htrans = 2'b00;
      bus.hwrite = 1'b0;
      bus.haddr = 32'h0;
      bus.hsize = 3'd0;
      bus.hwdata = 32'h0;
      test_reset;
      test_raw;
      test_byte_merge;
      test_oob;
      test_misalign;
      test_hold;
      test_rst_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
